// File: rtl/request_dispatcher.sv
// Elevator request dispatcher: picks the next floor to serve with a SCAN
// preference, drives the motion unit, then holds the doors open for DWELL cycles.
//
// state       | meaning
// ST_IDLE     | no operation in progress; next dispatch decision made here
// ST_DISPATCH | car travelling to target; go high, target/dir frozen
// ST_DWELL    | car at target; doors open, clr pulsed in first cycle
module request_dispatcher #(
  parameter int DWELL = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] floor,
  input  logic       arrived,
  output logic [1:0] target,
  output logic       go,
  output logic       dir,
  output logic [3:0] clr,
  output logic       door_open,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DWELL    = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] target_n;
  logic       dir_n;
  logic [7:0] cnt, cnt_n;

  logic       up_found, dn_found;
  logic [1:0] up_t, dn_t;

  // Nearest requested floor strictly above / strictly below the car.
  always_comb begin
    up_found = 1'b0;
    up_t     = 2'd0;
    dn_found = 1'b0;
    dn_t     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (2'(i) > floor && req[i]) begin
        up_found = 1'b1;
        up_t     = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < floor && req[i]) begin
        dn_found = 1'b1;
        dn_t     = 2'(i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    dir_n    = dir;
    cnt_n    = cnt;
    case (state)
      ST_IDLE: begin
        cnt_n = 8'd0;
        if (req[floor]) begin
          state_n  = ST_DWELL;
          target_n = floor;
        end else if (req != 4'd0) begin
          state_n = ST_DISPATCH;
          if (dir) begin
            if (up_found) begin
              target_n = up_t;
              dir_n    = 1'b1;
            end else begin
              target_n = dn_t;
              dir_n    = 1'b0;
            end
          end else begin
            if (dn_found) begin
              target_n = dn_t;
              dir_n    = 1'b0;
            end else begin
              target_n = up_t;
              dir_n    = 1'b1;
            end
          end
        end
      end
      ST_DISPATCH: begin
        if (arrived) begin
          state_n = ST_DWELL;
          cnt_n   = 8'd0;
        end
      end
      ST_DWELL: begin
        if (cnt == 8'(DWELL - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      target <= 2'd0;
      dir    <= 1'b1;
      cnt    <= 8'd0;
    end else begin
      state  <= state_n;
      target <= target_n;
      dir    <= dir_n;
      cnt    <= cnt_n;
    end
  end

  // Outputs decode from registered state only, so reset forces them the same edge.
  assign go        = (state == ST_DISPATCH);
  assign door_open = (state == ST_DWELL);
  assign busy      = (state != ST_IDLE);
  assign clr       = (state == ST_DWELL && cnt == 8'd0) ? (4'b0001 << target) : 4'b0000;

endmodule

// File: tb/tb_request_dispatcher.sv
// Self-checking bench for request_dispatcher (DWELL = 4): directed vector table,
// hand-written corner sequences, and randomized traffic against a behavioural model.
module tb_request_dispatcher;

  localparam int DW = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] floor;
  logic       arrived;
  logic [1:0] target;
  logic       go;
  logic       dir;
  logic [3:0] clr;
  logic       door_open;
  logic       busy;

  int checks = 0;
  int errors = 0;

  request_dispatcher #(.DWELL(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .floor(floor), .arrived(arrived),
    .target(target), .go(go), .dir(dir), .clr(clr), .door_open(door_open), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] fl;
    logic       arr;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {go, target, dir, clr, door_open, busy}
  function automatic logic [9:0] pk(input logic g, input logic [1:0] t, input logic d,
                                    input logic [3:0] c, input logic o, input logic b);
    return {g, t, d, c, o, b};
  endfunction

  function automatic logic [9:0] dut_vec();
    return pk(go, target, dir, clr, door_open, busy);
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic [1:0] f, input logic a,
                     input logic g, input logic [1:0] t, input logic d, input logic [3:0] c,
                     input logic o, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.fl = f; v.arr = a; v.exp = pk(g, t, d, c, o, b);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the car is doing, where it is headed, doors remaining.
  int m_mode = 0;     // 0 waiting, 1 travelling, 2 doors open
  int m_tgt  = 0;
  bit m_up   = 1'b1;
  int m_left = 0;
  bit m_first = 1'b0;

  task automatic scan(input logic [3:0] q, input int f, input bit up, output int t, output bit nup);
    int c;
    t = -1; nup = up;
    for (int d = 1; d <= 3 && t < 0; d++) begin
      c = up ? f + d : f - d;
      if (c >= 0 && c <= 3) if (q[c]) begin t = c; nup = up; end
    end
    for (int d = 1; d <= 3 && t < 0; d++) begin
      c = up ? f - d : f + d;
      if (c >= 0 && c <= 3) if (q[c]) begin t = c; nup = !up; end
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] q, input logic [1:0] f, input logic a);
    int t; bit nup;
    if (!r) begin
      m_mode = 0; m_tgt = 0; m_up = 1'b1; m_left = 0; m_first = 1'b0;
    end else if (m_mode == 0) begin
      if (q[f]) begin
        m_tgt = int'(f); m_mode = 2; m_left = DW; m_first = 1'b1;
      end else if (q != 4'd0) begin
        scan(q, int'(f), m_up, t, nup);
        m_tgt = t; m_up = nup; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (a) begin m_mode = 2; m_left = DW; m_first = 1'b1; end
    end else begin
      m_first = 1'b0;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask

  function automatic logic [9:0] model_vec();
    logic [3:0] c;
    c = (m_mode == 2 && m_first) ? (4'b0001 << m_tgt) : 4'b0000;
    return pk(m_mode == 1, 2'(m_tgt), m_up, c, m_mode == 2, m_mode != 0);
  endfunction

  task automatic cyc(input logic r, input logic [3:0] q, input logic [1:0] f, input logic a);
    reset = r; req = q; floor = f; arrived = a;
    @(posedge clk);
    model_step(r, q, f, a);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 4'd0; floor = 2'd0; arrived = 1'b0;

    // Reset dominance, SCAN up, service, direction hold/reversal, same-floor service
    add(0, 4'b1111, 0, 1,  0, 0, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 1,  0, 0, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 1, 4'b0000, 0, 0);
    add(1, 4'b0100, 0, 0,  1, 2, 1, 4'b0000, 0, 1);
    add(1, 4'b0100, 1, 0,  1, 2, 1, 4'b0000, 0, 1);
    add(1, 4'b0100, 2, 1,  0, 2, 1, 4'b0100, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 2, 0,  0, 2, 1, 4'b0000, 1, 1);
    add(1, 4'b0000, 2, 0,  0, 2, 1, 4'b0000, 0, 0);
    add(1, 4'b1001, 2, 0,  1, 3, 1, 4'b0000, 0, 1);
    add(1, 4'b1001, 3, 1,  0, 3, 1, 4'b1000, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0001, 3, 0,  0, 3, 1, 4'b0000, 1, 1);
    add(1, 4'b0001, 3, 0,  0, 3, 1, 4'b0000, 0, 0);
    add(1, 4'b0001, 3, 0,  1, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b0001, 0, 1,  0, 0, 0, 4'b0001, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0010, 1, 0,  0, 1, 0, 4'b0010, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 1, 0,  0, 1, 0, 4'b0000, 1, 1);
    add(1, 4'b0000, 1, 0,  0, 1, 0, 4'b0000, 0, 0);
    add(1, 4'b0000, 1, 1,  0, 1, 0, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].fl, vecs[i].arr);
      chk($sformatf("vec[%0d]", i), 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // No retargeting while travelling; clr follows target even if floor differs
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b1000, 0, 0);
    chk("disp_go", 32'(go), 32'd1);
    chk("disp_tgt", 32'(target), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 4'b1100, 2'(i % 3), 0);
      chk("noretarget_tgt", 32'(target), 32'd3);
      chk("noretarget_dir", 32'(dir), 32'd1);
    end
    cyc(1, 4'b1100, 2, 1);
    chk("arr_go", 32'(go), 32'd0);
    chk("clr_from_target", 32'(clr), 32'b1000);
    for (int i = 0; i < 4; i++) cyc(1, 4'b0100, 3, 0);
    chk("dwell_done_busy", 32'(busy), 32'd0);
    cyc(1, 4'b0100, 3, 0);
    chk("later_tgt", 32'(target), 32'd2);
    chk("later_dir", 32'(dir), 32'd0);
    chk("later_go", 32'(go), 32'd1);

    // Reset aborts a dwell; no clr afterwards
    cyc(0, 4'b0000, 1, 0);
    cyc(1, 4'b0010, 1, 0);
    chk("dwell_entry_clr", 32'(clr), 32'b0010);
    cyc(1, 4'b0010, 1, 0);
    chk("dwell2_door", 32'(door_open), 32'd1);
    cyc(0, 4'b0010, 1, 1);
    chk("abort_vec", 32'(dut_vec()), 32'(pk(0, 0, 1, 4'b0000, 0, 0)));
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4'b0000, 1, 0);
      chk("post_reset_clr", 32'(clr), 32'd0);
    end

    // Randomized traffic against the model
    cyc(0, 4'b0000, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r; logic [3:0] q; logic a;
      r = ($urandom_range(0, 99) != 0);
      q = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      a = ($urandom_range(0, 3) == 0);
      cyc(r, q, 2'($urandom), a);
      chk("rand", 32'(dut_vec()), 32'(model_vec()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
